// File: rtl/product_accumulator.sv
// -----------------------------------------------------------------------------
// product_accumulator
//   Downstream stage of the pipelined multiplier. Sums LEN consecutive valid
//   products into one frame sum and presents it on a valid/ready register.
//   The multiplier cannot be stalled, so a completed sum that cannot be
//   delivered is dropped and flagged with the sticky ovr bit.
//
//   Optional feature macro: SATURATE_EN
//     defined   : additions clamp to 2^ACC_W-1 and sat reports a clamped frame
//     undefined : additions wrap modulo 2^ACC_W and sat is tied 0
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   asynchronous reset, active-high
//   product  in   [P_W]   unsigned product from the multiplier
//   prod_vld in   product valid strobe (may be back-to-back)
//   clr      in   synchronous frame abort (clears acc, cnt, ovr)
//   sum_out  out  [ACC_W] completed frame sum
//   sum_vld  out  sum_out valid
//   sum_rdy  in   consumer accepts sum_out on a posedge with sum_vld=1
//   cnt      out  [CNT_W] products accumulated in the current frame
//   ovr      out  sticky: a completed sum was dropped
//   sat      out  sum_out was clamped (SATURATE_EN only)
// -----------------------------------------------------------------------------
module product_accumulator #(
    parameter int unsigned P_W   = 11,
    parameter int unsigned LEN   = 8,
    parameter int unsigned ACC_W = 14,
    parameter int unsigned CNT_W = $clog2(LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [P_W-1:0]   product,
    input  logic             prod_vld,
    input  logic             clr,
    output logic [ACC_W-1:0] sum_out,
    output logic             sum_vld,
    input  logic             sum_rdy,
    output logic [CNT_W-1:0] cnt,
    output logic             ovr,
    output logic             sat
);

    localparam logic [CNT_W-1:0] LAST_POS = CNT_W'(LEN - 1);

    logic [ACC_W-1:0] acc_q,     acc_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [ACC_W-1:0] sum_out_q, sum_out_d;
    logic             sum_vld_q, sum_vld_d;
    logic             ovr_q,     ovr_d;

    logic [ACC_W-1:0] base_c;
    logic [ACC_W-1:0] next_sum_c;
    logic             clamp_c;

`ifdef SATURATE_EN
    logic             frame_sat_q, frame_sat_d;
    logic             sat_q,       sat_d;
    logic [ACC_W:0]   wide_sum_c;
`endif

    // Running-sum adder; position 0 always starts from zero.
    always_comb begin
        base_c = (cnt_q == '0) ? '0 : acc_q;
`ifdef SATURATE_EN
        wide_sum_c = {1'b0, base_c} + (ACC_W + 1)'(product);
        // Once clamped, the frame stays clamped until it completes.
        clamp_c    = wide_sum_c[ACC_W] || ((cnt_q != '0) && frame_sat_q);
        next_sum_c = clamp_c ? '1 : wide_sum_c[ACC_W-1:0];
`else
        clamp_c    = 1'b0;
        next_sum_c = base_c + ACC_W'(product);
`endif
    end

    // Frame position, accumulator and output-stage next state.
    always_comb begin
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        sum_out_d = sum_out_q;
        sum_vld_d = sum_vld_q;
        ovr_d     = ovr_q;
`ifdef SATURATE_EN
        frame_sat_d = frame_sat_q;
        sat_d       = sat_q;
`endif

        // Consumer handshake; a sum completing on this edge overrides below.
        if (sum_vld_q && sum_rdy) begin
            sum_vld_d = 1'b0;
        end

        if (clr) begin
            acc_d = '0;
            cnt_d = '0;
            ovr_d = 1'b0;
`ifdef SATURATE_EN
            frame_sat_d = 1'b0;
`endif
        end else if (prod_vld) begin
            if (cnt_q == LAST_POS) begin
                acc_d = '0;
                cnt_d = '0;
`ifdef SATURATE_EN
                frame_sat_d = 1'b0;
`endif
                if (!sum_vld_q || sum_rdy) begin
                    sum_out_d = next_sum_c;
                    sum_vld_d = 1'b1;
`ifdef SATURATE_EN
                    sat_d     = clamp_c;
`endif
                end else begin
                    // Output still held: drop the new sum, keep the old one.
                    ovr_d = 1'b1;
                end
            end else begin
                acc_d = next_sum_c;
                cnt_d = cnt_q + CNT_W'(1);
`ifdef SATURATE_EN
                frame_sat_d = clamp_c;
`endif
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            sum_out_q <= '0;
            sum_vld_q <= 1'b0;
            ovr_q     <= 1'b0;
`ifdef SATURATE_EN
            frame_sat_q <= 1'b0;
            sat_q       <= 1'b0;
`endif
        end else begin
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            sum_out_q <= sum_out_d;
            sum_vld_q <= sum_vld_d;
            ovr_q     <= ovr_d;
`ifdef SATURATE_EN
            frame_sat_q <= frame_sat_d;
            sat_q       <= sat_d;
`endif
        end
    end

    assign sum_out = sum_out_q;
    assign sum_vld = sum_vld_q;
    assign cnt     = cnt_q;
    assign ovr     = ovr_q;
`ifdef SATURATE_EN
    assign sat     = sat_q;
`else
    assign sat     = 1'b0;
`endif

endmodule
